// File: rtl/k12_regfile_param.sv
// k12_regfile_param: NREGS x WIDTH register bank with a hi:lo pair
// that increments, decrements or loads pc+1 through a two-pass adder.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   op_valid/op_ready   operation handshake; op selects the operation
//                       (0 NOP, 1 WR, 2 CPY, 3 LD, 4 RDIO, 5 INC, 6 DEC, 7 RCALL)
//   dst, src            destination / copy-source register index
//   alures, memdata,
//   iodata, pc          write data sources
//   rsel0/1, rdata0/1   combinational read ports (0 for an index >= NREGS)
//   pair                {R[NREGS-2], R[NREGS-1]}
//   done                one-cycle pulse after a pair op completes
//   wrap                sticky INC/DEC wrap flag, cleared by the next pair op
module k12_regfile_param #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int IDXW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [2:0]         op,
    input  logic [IDXW-1:0]    dst,
    input  logic [IDXW-1:0]    src,
    input  logic [WIDTH-1:0]   alures,
    input  logic [WIDTH-1:0]   memdata,
    input  logic [WIDTH-1:0]   iodata,
    input  logic [2*WIDTH-1:0] pc,
    input  logic [IDXW-1:0]    rsel0,
    input  logic [IDXW-1:0]    rsel1,
    output logic [WIDTH-1:0]   rdata0,
    output logic [WIDTH-1:0]   rdata1,
    output logic [2*WIDTH-1:0] pair,
    output logic               done,
    output logic               wrap
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WR    = 3'd1;
    localparam logic [2:0] OP_CPY   = 3'd2;
    localparam logic [2:0] OP_LD    = 3'd3;
    localparam logic [2:0] OP_RDIO  = 3'd4;
    localparam logic [2:0] OP_INC   = 3'd5;
    localparam logic [2:0] OP_DEC   = 3'd6;
    localparam logic [2:0] OP_RCALL = 3'd7;

    localparam int HI_IDX = NREGS - 2;
    localparam int LO_IDX = NREGS - 1;
    localparam logic [IDXW:0] NREGS_L = (IDXW+1)'(NREGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI
    } state_t;

    state_t             state_q;
    logic               rdy_q;
    logic               done_q;
    logic               wrap_q;
    logic [WIDTH-1:0]   r_q [NREGS];
    logic [2*WIDTH-1:0] opnd_q;
    logic               dec_q;
    logic               rcall_q;
    logic [WIDTH-1:0]   tmp_lo_q;
    logic               c_q;

    logic               accept;
    logic               is_pair;
    logic               wr_en;
    logic               dst_ok;
    logic               src_ok;
    logic [WIDTH-1:0]   wr_val;
    logic [WIDTH-1:0]   lo_add;
    logic [WIDTH-1:0]   hi_add;
    logic [WIDTH:0]     lo_sum_d;
    logic [WIDTH:0]     hi_sum_d;
    logic               wrap_d;

    // rdy_q is low out of reset so the first acceptance is one cycle
    // after release; it is only ever high in S_IDLE.
    assign op_ready = rdy_q;
    assign accept   = op_valid && rdy_q;
    assign done     = done_q;
    assign wrap     = wrap_q;
    assign pair     = {r_q[HI_IDX], r_q[LO_IDX]};

    assign dst_ok  = {1'b0, dst} < NREGS_L;
    assign src_ok  = {1'b0, src} < NREGS_L;
    assign is_pair = (op == OP_INC) || (op == OP_DEC) || (op == OP_RCALL);

    always_comb begin
        wr_val = '0;
        wr_en  = 1'b0;
        case (op)
            OP_WR:   begin wr_val = alures;  wr_en = 1'b1; end
            OP_CPY:  begin
                wr_val = src_ok ? r_q[src] : '0;
                wr_en  = 1'b1;
            end
            OP_LD:   begin wr_val = memdata; wr_en = 1'b1; end
            OP_RDIO: begin wr_val = iodata;  wr_en = 1'b1; end
            default: begin wr_val = '0;      wr_en = 1'b0; end
        endcase
        wr_en = wr_en && dst_ok && accept;
    end

    // Two-pass adder: DEC adds all-ones to each half, INC/RCALL add 1
    // to the low half; the low carry feeds the high pass.
    always_comb begin
        lo_add   = dec_q ? '1 : WIDTH'(1);
        hi_add   = dec_q ? '1 : '0;
        lo_sum_d = {1'b0, opnd_q[WIDTH-1:0]} + {1'b0, lo_add};
        hi_sum_d = {1'b0, opnd_q[2*WIDTH-1:WIDTH]} + {1'b0, hi_add}
                 + {{WIDTH{1'b0}}, c_q};
        // DEC wraps exactly when the high pass produces no carry.
        wrap_d   = !rcall_q && (dec_q ? !hi_sum_d[WIDTH] : hi_sum_d[WIDTH]);
    end

    always_comb begin
        rdata0 = '0;
        rdata1 = '0;
        if ({1'b0, rsel0} < NREGS_L) rdata0 = r_q[rsel0];
        if ({1'b0, rsel1} < NREGS_L) rdata1 = r_q[rsel1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_q    <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            opnd_q   <= '0;
            dec_q    <= 1'b0;
            rcall_q  <= 1'b0;
            tmp_lo_q <= '0;
            c_q      <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rdy_q <= !(accept && is_pair);
                    if (accept && is_pair) begin
                        opnd_q  <= (op == OP_RCALL) ? pc : pair;
                        dec_q   <= (op == OP_DEC);
                        rcall_q <= (op == OP_RCALL);
                        wrap_q  <= 1'b0;
                        state_q <= S_LO;
                    end else if (wr_en) begin
                        r_q[dst] <= wr_val;
                    end
                end
                S_LO: begin
                    tmp_lo_q <= lo_sum_d[WIDTH-1:0];
                    c_q      <= lo_sum_d[WIDTH];
                    state_q  <= S_HI;
                end
                S_HI: begin
                    r_q[HI_IDX] <= hi_sum_d[WIDTH-1:0];
                    r_q[LO_IDX] <= tmp_lo_q;
                    wrap_q      <= wrap_d;
                    done_q      <= 1'b1;
                    rdy_q       <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
